// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_detect_pkg;

  // Overlap mode: ON keeps the pattern's longest proper border after a match,
  // OFF restarts the search from state 0.
  typedef enum logic {
    OVL_OFF = 1'b0,
    OVL_ON  = 1'b1
  } ovl_mode_e;

  // State register width: enough to encode 0..n-1, never narrower than 1 bit.
  function automatic int state_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state logic for the sequence detector: finds the longest
// pattern prefix that is a suffix of (matched prefix ++ xin), and the
// pattern's longest proper border for overlapping restarts.
module seq_next_state
  import seq_detect_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  pattern_reg,
  input  logic [SW-1:0] state,
  input  logic          xin,
  input  logic          overlap,
  output logic [SW-1:0] next_state,
  output logic          match
);

  int unsigned s_i;
  int unsigned best;
  int unsigned border;
  logic        ok;
  logic        ok_b;
  logic        t_bit;

  // Longest k in 0..s+1 whose pattern prefix equals the tail of prefix_s ++ xin.
  always_comb begin
    s_i   = 32'(state);
    best  = 0;
    ok    = 1'b0;
    t_bit = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      ok = (k <= s_i + 1);
      for (int unsigned j = 0; j < N; j++) begin
        if (ok && (j < k)) begin
          // Position s_i is the incoming bit; earlier positions come from the pattern prefix.
          if ((s_i + 1 - k + j) == s_i)
            t_bit = xin;
          else
            t_bit = pattern_reg[N-1-(s_i+1-k+j)];
          if (t_bit != pattern_reg[N-1-j])
            ok = 1'b0;
        end
      end
      if (ok)
        best = k;
    end
  end

  // Longest proper border: prefix of length k equal to suffix of length k, k < N.
  always_comb begin
    border = 0;
    ok_b   = 1'b0;
    for (int unsigned k = 1; k < N; k++) begin
      ok_b = 1'b1;
      for (int unsigned j = 0; j < N; j++) begin
        if ((j < k) && (pattern_reg[N-1-j] != pattern_reg[k-1-j]))
          ok_b = 1'b0;
      end
      if (ok_b)
        border = k;
    end
  end

  // Select next state: a full match restarts at the border or at zero.
  always_comb begin
    match      = (best == N);
    next_state = SW'(best);
    if (match)
      next_state = (overlap == OVL_ON) ? SW'(border) : '0;
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Programmable serial sequence detector with loadable pattern and start state,
// overlap/non-overlap mode, registered match pulse and saturating match counter.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] PATTERN_RST = 4'b0111,
  parameter int           CNT_W       = 8,
  localparam int          SW          = state_width(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             xin,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pattern,
  input  logic [SW-1:0]    start_state,
  output logic             y,
  output logic [SW-1:0]    state_o,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  logic [N-1:0]     pattern_reg;
  logic [SW-1:0]    next_state;
  logic             match;
  logic [SW-1:0]    start_clamped;
  logic [CNT_W-1:0] cnt_inc;

  seq_next_state #(
    .N  (N),
    .SW (SW)
  ) u_next (
    .pattern_reg (pattern_reg),
    .state       (state_o),
    .xin         (xin),
    .overlap     (overlap),
    .next_state  (next_state),
    .match       (match)
  );

  // Clamp the loaded start state into 0..N-1 and form the saturating increment.
  always_comb begin
    start_clamped = start_state;
    if (int'(start_state) > N - 1)
      start_clamped = SW'(N - 1);
    cnt_inc = (match_count == '1) ? match_count : match_count + 1'b1;
  end

  // State, pattern, match pulse and counter registers; load beats enable beats hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_o     <= '0;
      pattern_reg <= PATTERN_RST;
      y           <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (load) begin
      pattern_reg <= pattern;
      state_o     <= start_clamped;
      y           <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else if (enable) begin
      state_o <= next_state;
      y       <= match;
      if (match) begin
        match_count <= cnt_inc;
        count_sat   <= &cnt_inc;
      end
    end else begin
      y <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench for seq_detect_fsm: directed scenarios plus random
// stimulus against a history-based reference model.
module tb_seq_detect_fsm;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       xin;
  logic       overlap;
  logic       load;
  logic [3:0] pattern;
  logic [1:0] start_state;
  logic [4:0] pattern5;
  logic [2:0] start5;

  logic       y,  y2,  y5;
  logic [1:0] state_o, state2;
  logic [2:0] state5;
  logic [7:0] match_count, mc5;
  logic [1:0] mc2;
  logic       count_sat, sat2, sat5;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pattern, recent consumed bits, expected pulse and counts.
  logic [3:0] m_pat;
  bit         m_hist[$];
  logic       m_y;
  int         m_cnt;
  int         m_cnt2;

  always #5 clock = ~clock;

  seq_detect_fsm #(.N(4), .PATTERN_RST(4'b0111), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .xin(xin), .overlap(overlap),
    .load(load), .pattern(pattern), .start_state(start_state),
    .y(y), .state_o(state_o), .match_count(match_count), .count_sat(count_sat));

  seq_detect_fsm #(.N(4), .PATTERN_RST(4'b0111), .CNT_W(2)) dut_c2 (
    .clock(clock), .reset(reset), .enable(enable), .xin(xin), .overlap(overlap),
    .load(load), .pattern(pattern), .start_state(start_state),
    .y(y2), .state_o(state2), .match_count(mc2), .count_sat(sat2));

  seq_detect_fsm #(.N(5), .PATTERN_RST(5'b00111), .CNT_W(8)) dut_n5 (
    .clock(clock), .reset(reset), .enable(enable), .xin(xin), .overlap(overlap),
    .load(load), .pattern(pattern5), .start_state(start5),
    .y(y5), .state_o(state5), .match_count(mc5), .count_sat(sat5));

  // Expected state: longest recent-bit suffix that is a proper pattern prefix.
  function automatic int m_state();
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < N; k++) begin
      if (k <= m_hist.size()) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++)
          if (m_hist[m_hist.size() - k + j] != m_pat[N-1-j]) ok = 1'b0;
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_pat = 4'b0111;
    m_hist.delete();
    m_y    = 1'b0;
    m_cnt  = 0;
    m_cnt2 = 0;
  endtask

  // Drive one cycle of inputs, advance the model with the same inputs, settle.
  task automatic step(input logic en, input logic x, input logic ld, input logic ov,
                      input logic [3:0] pat, input logic [1:0] st);
    int lim;
    bit hit;
    enable = en; xin = x; load = ld; overlap = ov; pattern = pat; start_state = st;
    @(posedge clock);
    if (ld) begin
      m_pat = pat;
      m_hist.delete();
      lim = (int'(st) > N - 1) ? N - 1 : int'(st);
      for (int i = 0; i < lim; i++) m_hist.push_back(pat[N-1-i]);
      m_y = 1'b0; m_cnt = 0; m_cnt2 = 0;
    end else if (en) begin
      m_hist.push_back(x);
      if (m_hist.size() > N) void'(m_hist.pop_front());
      hit = (m_hist.size() == N);
      for (int i = 0; i < m_hist.size(); i++)
        if (m_hist[i] != m_pat[N-1-i]) hit = 1'b0;
      m_y = hit;
      if (hit) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        if (!ov) m_hist.delete();
      end
    end else begin
      m_y = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 0; xin = 0; overlap = 1; load = 0;
    pattern = '0; start_state = '0; pattern5 = '0; start5 = '0;
    model_reset();
    #7;
    n_checks++;
    if ({y, state_o, match_count, count_sat} !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want all zero", {y, state_o, match_count, count_sat});
    end
    n_checks++;
    if ({y2, state2, mc2, sat2} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs_c2: got %b want all zero", {y2, state2, mc2, sat2});
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_default_stream();
    logic [8:0] bits;
    bits = 9'b011110011;
    for (int i = 0; i < 9; i++) begin
      step(1'b1, bits[8-i], 1'b0, 1'b1, 4'b0000, 2'd0);
      n_checks++;
      if (y !== (i == 3)) begin
        n_fail++; $display("FAIL default_y bit %0d: got %b want %b", i + 1, y, (i == 3));
      end
      n_checks++;
      if (int'(state_o) != m_state()) begin
        n_fail++; $display("FAIL default_state bit %0d: got %0d want %0d", i + 1, state_o, m_state());
      end
    end
    n_checks++;
    if (match_count !== 8'd1) begin
      n_fail++; $display("FAIL default_count: got %0d want 1", match_count);
    end
    n_checks++;
    if (state_o !== 2'd3) begin
      n_fail++; $display("FAIL default_final_state: got %0d want 3", state_o);
    end
  endtask

  task automatic test_load_1011();
    logic [6:0] bits;
    bits = 7'b1011011;
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, 2'd0);
      for (int i = 0; i < 7; i++) begin
        step(1'b1, bits[6-i], 1'b0, (pass == 0), 4'b0000, 2'd0);
        n_checks++;
        if (y !== ((i == 3) || (pass == 0 && i == 6))) begin
          n_fail++; $display("FAIL load1011_y ovl=%0d bit %0d: got %b want %b",
                             pass == 0, i + 1, y, ((i == 3) || (pass == 0 && i == 6)));
        end
      end
      n_checks++;
      if (int'(match_count) != ((pass == 0) ? 2 : 1)) begin
        n_fail++; $display("FAIL load1011_count ovl=%0d: got %0d want %0d",
                           pass == 0, match_count, (pass == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_start_state();
    pattern5 = 5'b00111; start5 = 3'd7;
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0111, 2'd3);
    n_checks++;
    if (state_o !== 2'd3) begin
      n_fail++; $display("FAIL start_state_load: got %0d want 3", state_o);
    end
    n_checks++;
    if (state5 !== 3'd4) begin
      n_fail++; $display("FAIL start_state_clamp_n5: got %0d want 4", state5);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0);
    n_checks++;
    if ({y, match_count} !== {1'b1, 8'd1}) begin
      n_fail++; $display("FAIL start_state_match: got y=%b cnt=%0d want y=1 cnt=1", y, match_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] held;
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0);
      n_checks++;
      if (y !== (i >= 3)) begin
        n_fail++; $display("FAIL b2b_y bit %0d: got %b want %b", i + 1, y, (i >= 3));
      end
    end
    held = state_o;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0);
      n_checks++;
      if ({y, state_o} !== {1'b0, 2'd3}) begin
        n_fail++; $display("FAIL b2b_hold cycle %0d: got y=%b state=%0d want y=0 state=3 (was %0d)",
                           i, y, state_o, held);
      end
    end
    n_checks++;
    if (match_count !== 8'd3) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 3", match_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0);
      if (i >= 3) begin
        n_checks++;
        if ({y2, mc2, sat2} !== {1'b1, exp_cnt[i-3], (i >= 5)}) begin
          n_fail++; $display("FAIL sat_c2 match %0d: got y=%b cnt=%0d sat=%b want y=1 cnt=%0d sat=%b",
                             i - 2, y2, mc2, sat2, exp_cnt[i-3], (i >= 5));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits;
    bits = 4'b1011;
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b1, bits[3-i], 1'b0, 1'b1, 4'b0000, 2'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0);
    n_checks++;
    if ({state_o, match_count} !== {2'd2, 8'd1}) begin
      n_fail++; $display("FAIL areset_pre: got state=%0d cnt=%0d want state=2 cnt=1", state_o, match_count);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({y, state_o, match_count, count_sat} !== 12'h000) begin
      n_fail++; $display("FAIL areset_immediate: got %b want all zero", {y, state_o, match_count, count_sat});
    end
    #1 reset = 1'b0;
    model_reset();
    bits = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[3-i], 1'b0, 1'b1, 4'b1011, 2'd0);
      n_checks++;
      if (y !== (i == 3)) begin
        n_fail++; $display("FAIL areset_pattern bit %0d: got y=%b want %b", i + 1, y, (i == 3));
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, bits[3-i], 1'b0, 1'b1, 4'b0000, 2'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 2'd0);
    n_checks++;
    if ({y, state_o, match_count} !== {1'b0, 2'd0, 8'd0}) begin
      n_fail++; $display("FAIL load_beats_enable: got y=%b state=%0d cnt=%0d want 0/0/0", y, state_o, match_count);
    end
  endtask

  task automatic test_random();
    logic       en, x, ld, ov;
    logic [3:0] pat;
    logic [1:0] st;
    for (int c = 0; c < 600; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      x   = 1'($urandom_range(0, 1));
      ld  = ($urandom_range(0, 24) == 0);
      ov  = ($urandom_range(0, 3) != 0);
      pat = 4'($urandom_range(0, 15));
      st  = 2'($urandom_range(0, 3));
      step(en, x, ld, ov, pat, st);
      n_checks++;
      if ({y, y2} !== {m_y, m_y}) begin
        n_fail++; $display("FAIL rand_y cycle %0d: got %b/%b want %b", c, y, y2, m_y);
      end
      n_checks++;
      if (int'(state_o) != m_state()) begin
        n_fail++; $display("FAIL rand_state cycle %0d: got %0d want %0d", c, state_o, m_state());
      end
      n_checks++;
      if ((int'(match_count) != m_cnt) || (count_sat !== (m_cnt == 255))) begin
        n_fail++; $display("FAIL rand_count cycle %0d: got %0d sat=%b want %0d", c, match_count, count_sat, m_cnt);
      end
      n_checks++;
      if ((int'(mc2) != m_cnt2) || (sat2 !== (m_cnt2 == 3))) begin
        n_fail++; $display("FAIL rand_count_c2 cycle %0d: got %0d sat=%b want %0d sat=%b",
                           c, mc2, sat2, m_cnt2, (m_cnt2 == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_stream();
    test_load_1011();
    test_start_state();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
